// File: rtl/urv_uart_pkg.sv
// Shared constants for the uRV UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package urv_uart_pkg;

  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int BUSY_BIT  = 2;
  localparam int OVF_BIT   = 3;
  localparam int LEVEL_LSB = 4;
  localparam int LEVEL_MSB = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/urv_uart_tx_if.sv
// uRV data-memory bus as seen by a memory-mapped peripheral.
// master = CPU side, slave = peripheral side.
interface urv_uart_tx_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic [31:0] dm_data_l_o;
  logic        sel_o;

  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i,
    input  dm_data_l_o, sel_o
  );

  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i,
    output dm_data_l_o, sel_o
  );
endinterface

// File: rtl/urv_sync_fifo.sv
// Synchronous FIFO, first-word-fall-through dout; push/pop take effect at the edge.
// A push while full is accepted only together with a pop; otherwise it is ignored.
module urv_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk_i,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/urv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter; loads return one cycle after the address.
// Stores into a full FIFO are dropped and latch the sticky overflow flag.
module urv_uart_tx
  import urv_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0010,
  parameter int          CLK_DIV   = 104,
  parameter int          FIFO_AW   = 3
) (
  input  logic         clk_i,
  input  logic         rst,
  urv_uart_tx_if.slave bus,
  output logic         txd_o
);

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic               sel;
  logic               lane_store;
  logic               wr_txdata;
  logic               wr_status;
  logic               push_ok;
  logic               pop;
  logic               full;
  logic               empty;
  logic [7:0]         fifo_dout;
  logic [FIFO_AW:0]   level;
  logic               ovf;
  logic [31:0]        status;
  logic               unused_bits;

  tx_state_t   state, state_d;
  logic [15:0] baud, baud_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shift, shift_d;
  logic        txd_d;

  assign sel         = (bus.dm_addr_i[31:3] == BASE_ADDR[31:3]);
  assign bus.sel_o   = sel;
  assign lane_store  = sel && bus.dm_store_i && bus.dm_data_select_i[0];
  assign wr_txdata   = lane_store && (bus.dm_addr_i[2] == TXDATA_OFS[2]);
  assign wr_status   = lane_store && (bus.dm_addr_i[2] == STATUS_OFS[2]);
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok     = !full || pop;
  assign unused_bits = ^{bus.dm_addr_i[1:0], bus.dm_data_s_i[31:8], bus.dm_data_select_i[3:1]};

  urv_sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk_i (clk_i),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (bus.dm_data_s_i[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    status                      = '0;
    status[FULL_BIT]            = full;
    status[EMPTY_BIT]           = empty;
    status[BUSY_BIT]            = (state != IDLE);
    status[OVF_BIT]             = ovf;
    status[LEVEL_MSB:LEVEL_LSB] = 4'(level);
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      ovf             <= 1'b0;
      bus.dm_data_l_o <= '0;
    end else begin
      if (wr_txdata && !push_ok)                       ovf <= 1'b1;
      else if (wr_status && bus.dm_data_s_i[OVF_BIT])  ovf <= 1'b0;
      bus.dm_data_l_o <= (sel && bus.dm_addr_i[2] == STATUS_OFS[2]) ? status : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_o   <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      txd_o   <= txd_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = DIV_M1;
          state_d = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_d    = DIV_M1;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_d  = DIV_M1;
          shift_d = shift >> 1;
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so back-to-back frames have no gap.
        if (baud == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            baud_d  = DIV_M1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_urv_uart_tx.sv
// Directed bench for urv_uart_tx: a frame-level model is checked every cycle,
// plus literal expectations for reset, framing, overflow and async reset.
module tb_urv_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0010;
  localparam int          DIV   = 4;
  localparam int          FRAME = 10 * DIV;

  logic clk_i = 1'b0;
  logic rst   = 1'b0;
  logic txd;

  urv_uart_tx_if bus ();

  urv_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_AW(3)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus),
    .txd_o (txd)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model: queue of pending bytes plus the frame currently on the line.
  byte unsigned q[$];
  logic [7:0]   cur      = '0;
  logic         active   = 1'b0;
  int           pos      = 0;
  logic         ovf_m    = 1'b0;
  logic [31:0]  exp_load = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [31:0] a);
    return (a & ~32'h7) == BASE;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (q.size() == 8);
    s[1]   = (q.size() == 0);
    s[2]   = active;
    s[3]   = ovf_m;
    s[7:4] = 4'(q.size());
    return s;
  endfunction

  // Line level for frame position pos: start bit, 8 data bits LSB first, stop bit.
  function automatic logic model_txd();
    int k;
    if (!active) return 1'b1;
    k = pos / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk_i) begin
    if (!rst) begin
      q.delete();
      active   = 1'b0;
      pos      = 0;
      ovf_m    = 1'b0;
      exp_load = '0;
    end else begin
      exp_load = (hit(bus.dm_addr_i) && bus.dm_addr_i[2]) ? model_status() : 32'h0;
      if (active) begin
        pos++;
        if (pos == FRAME) active = 1'b0;
      end
      if (!active && q.size() != 0) begin
        cur    = q.pop_front();
        active = 1'b1;
        pos    = 0;
      end
      if (bus.dm_store_i && hit(bus.dm_addr_i) && bus.dm_data_select_i[0]) begin
        if (!bus.dm_addr_i[2]) begin
          if (q.size() < 8) q.push_back(bus.dm_data_s_i[7:0]);
          else              ovf_m = 1'b1;
        end else if (bus.dm_data_s_i[3]) begin
          ovf_m = 1'b0;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    #1;
    chk("txd", 32'(txd), 32'(model_txd()));
    chk("load", bus.dm_data_l_o, exp_load);
    chk("sel", 32'(bus.sel_o), 32'(hit(bus.dm_addr_i)));
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] lanes);
    bus.dm_addr_i        = a;
    bus.dm_data_s_i      = d;
    bus.dm_data_select_i = lanes;
    bus.dm_store_i       = 1'b1;
    @(negedge clk_i);
    bus.dm_store_i       = 1'b0;
    bus.dm_data_select_i = 4'b0;
  endtask

  logic [9:0] f55 = 10'b10_1010_1010;

  initial begin
    bus.dm_addr_i        = '0;
    bus.dm_data_s_i      = '0;
    bus.dm_data_select_i = '0;
    bus.dm_store_i       = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_load", bus.dm_data_l_o, 32'h0);

    rst = 1'b1;
    bus.dm_addr_i = BASE + 32'd4;
    @(negedge clk_i);
    chk("rst_status", bus.dm_data_l_o, 32'h2);

    // Single 0x55 frame
    do_store(BASE, 32'h55, 4'b0001);
    bus.dm_addr_i = BASE + 32'd4;
    chk("f55_pre", 32'(txd), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk_i);
      chk("f55_txd", 32'(txd), 32'(f55[i/DIV]));
      if (i >= 1) chk("f55_busy", 32'(bus.dm_data_l_o[2]), 32'd1);
    end
    @(negedge clk_i);
    chk("f55_stop_busy", 32'(bus.dm_data_l_o[2]), 32'd1);
    @(negedge clk_i);
    chk("f55_idle", bus.dm_data_l_o, 32'h2);

    // Wrong lane and out-of-window stores
    do_store(BASE, 32'hAA, 4'b0010);
    bus.dm_addr_i = BASE + 32'd8;
    #2;
    chk("sel_out", 32'(bus.sel_o), 32'd0);
    do_store(BASE + 32'd8, 32'hAA, 4'b0001);
    bus.dm_addr_i = BASE + 32'd4;
    @(negedge clk_i);
    chk("lane_status", bus.dm_data_l_o, 32'h2);
    repeat (10) @(negedge clk_i);
    chk("lane_txd", 32'(txd), 32'd1);

    // Back-to-back frames
    do_store(BASE, 32'hA3, 4'b0001);
    do_store(BASE, 32'h3C, 4'b0001);
    bus.dm_addr_i = BASE + 32'd4;
    repeat (FRAME - 1) @(negedge clk_i);
    chk("b2b_stop", 32'(txd), 32'd1);
    @(negedge clk_i);
    chk("b2b_start", 32'(txd), 32'd0);
    repeat (FRAME) @(negedge clk_i);
    chk("b2b_busy_end", 32'(bus.dm_data_l_o[2]), 32'd1);
    @(negedge clk_i);
    chk("b2b_idle", bus.dm_data_l_o, 32'h2);

    // Fill past capacity: 0x01 goes to the line, 0x02..0x09 fill the FIFO, 0x0A drops
    for (int i = 1; i <= 10; i++) do_store(BASE, 32'(i), 4'b0001);
    bus.dm_addr_i = BASE + 32'd4;
    @(negedge clk_i);
    chk("ovf_status", bus.dm_data_l_o, 32'h8D);
    do_store(BASE + 32'd4, 32'h08, 4'b0001);
    chk("ovf_pre_clear", bus.dm_data_l_o, 32'h8D);
    @(negedge clk_i);
    chk("ovf_cleared", bus.dm_data_l_o, 32'h85);
    repeat (9 * FRAME + 5) @(negedge clk_i);
    chk("ovf_drained", bus.dm_data_l_o, 32'h2);

    // Asynchronous reset in the middle of data bit 3 of 0xF7 (bit 3 = 0)
    do_store(BASE, 32'hF7, 4'b0001);
    do_store(BASE, 32'h11, 4'b0001);
    bus.dm_addr_i = BASE + 32'd4;
    repeat (17) @(negedge clk_i);
    chk("mid_txd_low", 32'(txd), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_txd", 32'(txd), 32'd1);
    repeat (2) @(negedge clk_i);
    rst = 1'b1;
    @(negedge clk_i);
    chk("arst_status", bus.dm_data_l_o, 32'h2);
    repeat (60) @(negedge clk_i);
    chk("arst_idle", 32'(txd), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
